// File: rtl/ysyx_23060184_id_ex_stage.sv
// ID/EX pipeline register: valid/ready handshake with a one-entry skid buffer and Branch flush.
// Optional macro ID_EX_PERF_CNT_EN adds flush/stall performance counters.
module ysyx_23060184_id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_LENGTH = 5,
    parameter int CTRL_W     = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_rd1,
    input  logic [XLEN-1:0]       in_rd2,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [REG_LENGTH-1:0] in_rs1,
    input  logic [REG_LENGTH-1:0] in_rs2,
    input  logic [REG_LENGTH-1:0] in_rd,
    input  logic                  in_regwrite,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_rd1,
    output logic [XLEN-1:0]       out_rd2,
    output logic [XLEN-1:0]       out_imm,
    output logic [REG_LENGTH-1:0] Rs1E,
    output logic [REG_LENGTH-1:0] Rs2E,
    output logic [REG_LENGTH-1:0] RdE,
    output logic                  RegWriteE,
    output logic [CTRL_W-1:0]     out_ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           perf_flush_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int PW = 4 * XLEN + 3 * REG_LENGTH + 1 + CTRL_W;

    logic [PW-1:0]         w_in_payload;
    logic [PW-1:0]         r_main_d;
    logic [PW-1:0]         r_skid_d;
    logic                  r_main_v;
    logic                  r_skid_v;
    logic                  w_accept;
    logic                  w_main_v_nxt;
    logic                  w_skid_v_nxt;
    logic                  w_main_load;
    logic                  w_main_sel_skid;
    logic                  w_skid_load;
    logic [REG_LENGTH-1:0] w_rs1;
    logic [REG_LENGTH-1:0] w_rs2;
    logic [REG_LENGTH-1:0] w_rd;
    logic                  w_regwrite;

    assign w_in_payload = {in_pc, in_rd1, in_rd2, in_imm, in_rs1, in_rs2, in_rd, in_regwrite, in_ctrl};
    assign {out_pc, out_rd1, out_rd2, out_imm, w_rs1, w_rs2, w_rd, w_regwrite, out_ctrl} = r_main_d;

    // Ready depends only on the skid flag, so there is no path from out_ready.
    assign in_ready  = ~r_skid_v;
    assign w_accept  = in_valid & ~r_skid_v & ~flush;
    assign out_valid = r_main_v;

    // Bubbles present index 0 and no write so the hazard unit never forwards from them.
    assign Rs1E      = r_main_v ? w_rs1 : {REG_LENGTH{1'b0}};
    assign Rs2E      = r_main_v ? w_rs2 : {REG_LENGTH{1'b0}};
    assign RdE       = r_main_v ? w_rd  : {REG_LENGTH{1'b0}};
    assign RegWriteE = r_main_v & w_regwrite;

    // Next-state decision for the main/skid valid bits and their load strobes.
    always_comb begin
        w_main_v_nxt    = r_main_v;
        w_skid_v_nxt    = r_skid_v;
        w_main_load     = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        if (flush) begin
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else if (~r_main_v | out_ready) begin
            if (r_skid_v) begin
                w_main_load     = 1'b1;
                w_main_sel_skid = 1'b1;
                w_main_v_nxt    = 1'b1;
                w_skid_load     = w_accept;
                w_skid_v_nxt    = w_accept;
            end else if (w_accept) begin
                w_main_load  = 1'b1;
                w_main_v_nxt = 1'b1;
            end else begin
                w_main_v_nxt = 1'b0;
            end
        end else begin
            if (w_accept) begin
                w_skid_load  = 1'b1;
                w_skid_v_nxt = 1'b1;
            end else begin
                w_skid_load  = 1'b0;
            end
        end
    end

    // Valid-bit state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            r_main_v <= w_main_v_nxt;
            r_skid_v <= w_skid_v_nxt;
        end
    end

    // Payload registers; the skid entry always moves to main before any newer input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_main_d <= {PW{1'b0}};
            r_skid_d <= {PW{1'b0}};
        end else begin
            if (w_main_load) begin
                r_main_d <= w_main_sel_skid ? r_skid_d : w_in_payload;
            end
            if (w_skid_load) begin
                r_skid_d <= w_in_payload;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic w_flush_evt;
    logic w_stall_evt;

    assign w_flush_evt = flush & (r_main_v | r_skid_v | in_valid);
    assign w_stall_evt = r_main_v & ~out_ready;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_flush_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (w_flush_evt) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (w_stall_evt) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ysyx_23060184_id_ex_stage.md
Name: ysyx_23060184_id_ex_stage

Overview:
- ID/EX pipeline register with valid/ready handshake and a one-entry skid buffer.
- Sits between the decode stage and the execute stage.
- Supplies the execute-stage source/destination register indices and RegWrite that the hazard unit compares for forwarding.
- Consumes the hazard unit's Branch indication as a flush, so wrong-path instructions never reach EX.

Parameters:
XLEN, 32, datapath width (pc, operands, immediate)
REG_LENGTH, 5, register index width
CTRL_W, 16, width of the opaque decoded-control bundle (ALU op, mux selects, PCSrc, mem ctrl)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  decode has an instruction
in_ready  output  1  stage can accept this cycle
in_pc  input  XLEN  instruction PC
in_rd1  input  XLEN  register-file read data 1
in_rd2  input  XLEN  register-file read data 2
in_imm  input  XLEN  sign-extended immediate
in_rs1  input  REG_LENGTH  source register 1 index
in_rs2  input  REG_LENGTH  source register 2 index
in_rd  input  REG_LENGTH  destination index
in_regwrite  input  1  instruction writes rd
in_ctrl  input  CTRL_W  decoded control bundle
flush  input  1  hazard-unit Branch; kill all held and incoming entries
out_valid  output  1  EX holds a live instruction
out_ready  input  1  execute/downstream accepts
out_pc, out_rd1, out_rd2, out_imm  output  XLEN  registered copies
Rs1E, Rs2E, RdE  output  REG_LENGTH  registered indices to hazard unit / EX
RegWriteE  output  1  registered regwrite, qualified by out_valid
out_ctrl  output  CTRL_W  registered control bundle

Behaviour:
- Storage: main register (drives outputs) plus skid register. Each has its own valid bit (main_v, skid_v).
- Reset (rstn=0, async): main_v=0, skid_v=0, all data registers 0. Outputs: out_valid=0, all data 0, in_ready=1.
- in_ready = ~skid_v. Registered state only; no combinational path from out_ready.
- Accept = in_valid & in_ready & ~flush.
- Drain = main_v & out_ready.
- Latency: empty stage, accept at edge N → out_valid=1 with payload after edge N.
- Main update, when ~main_v | out_ready:
  - if skid_v, main ← skid and skid_v ← 0 (if Accept in the same cycle, skid ← input and skid_v stays 1);
  - else if Accept, main ← input;
  - else main_v ← 0.
- Main stalled (main_v & ~out_ready): if Accept, skid ← input and skid_v ← 1. The next in_ready is 0.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush.
- Payload stability: while out_valid & ~out_ready, all out_* hold their values.
- Flush priority: flush=1 at edge → main_v=0, skid_v=0 regardless of out_ready/in_valid. The incoming instruction is dropped. Data registers need not clear.
- Flush and Drain in the same cycle: the draining instruction is considered consumed; the flush still clears state.
- Bubble qualification:
  - when out_valid=0: Rs1E=0, Rs2E=0, RdE=0, RegWriteE=0;
  - the hazard unit therefore never forwards from a bubble;
  - other out_* are don't-care when invalid.
- Reset mid-operation: both entries are discarded immediately; no partial update after rstn deasserts. The first edge with rstn=1 obeys the normal rules.

Optional Feature:
Macro ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_flush_cnt (32) and perf_stall_cnt (32).
  - flush_cnt increments on each edge with flush=1 and (main_v|skid_v|in_valid).
  - stall_cnt increments on each edge with main_v & ~out_ready.
  - Both reset to 0 (async) and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rstn=0 mid-stream with both entries full → out_valid=0, in_ready=1, RegWriteE=0, Rs1E=0 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, in_valid=1 for 4 cycles, pc 0x80000000..0x8000000C → out_pc follows one cycle later in order; in_ready stays 1.
- Backpressure: out_ready=0 after the first accept, two more pushes offered → second accepted into skid, in_ready=0, third held off. Then out_ready=1 for 3 cycles → outputs 0x80000000, 0x80000004, 0x80000008 in order, none lost.
- Flush: main and skid full, flush=1 with in_valid=1 (pc 0x80000010) → next cycle out_valid=0, in_ready=1, pc 0x80000010 never appears.
- Bubble qualification: after flush, with in_rs1=5, in_rd=5, in_regwrite=1 not accepted → Rs1E=0, RdE=0, RegWriteE=0.
- Perf (ID_EX_PERF_CNT_EN): 3 stall cycles, then 1 flush → perf_stall_cnt=3, perf_flush_cnt=1.
